dff_chain_ctrl: RTL

Sequencer for a serial chain of rising-edge D flip-flops with synchronous reset. It accepts load and clear commands over a valid/ready handshake. A load shifts a WIDTH-bit word into the chain MSB-first, so that afterwards stage k holds bit k. A clear asserts the chain's synchronous reset for one cycle. The block sits between a register-programming master and the DFF chain, and owns the chain's D, enable and reset inputs.

---
 rtl/dff_chain_pkg.sv | 6 +
 rtl/dff_chain_ctrl.sv | 75 +++++++
 2 files changed

// File: rtl/dff_chain_pkg.sv
// dff_chain_pkg: command opcodes and sequencer state encoding shared by the DFF chain controller and its bench
package dff_chain_pkg;
    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_CLEAR = 1'b1;
    typedef enum logic [1:0] {IDLE, SHIFT, CLR, DONE} state_t;
endpackage

// File: rtl/dff_chain_ctrl.sv
// dff_chain_ctrl: sequences LOAD (MSB-first serial shift) and CLEAR (one-cycle sync reset) commands onto a DFF chain
//   clk, reset            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake; cmd_op 0=LOAD 1=CLEAR, cmd_data word to load
//   ser_d/chain_en        : serial data and shift enable driven to the chain
//   chain_rst             : chain synchronous reset (also asserted while reset is high)
//   busy/done             : command in progress / one-cycle completion pulse
module dff_chain_ctrl
    import dff_chain_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             ser_d,
    output logic             chain_en,
    output logic             chain_rst,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (cmd_op == OP_CLEAR) ? CLR : SHIFT;
                    shreg_d = cmd_data;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
            end
            CLR:  state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_comb begin
        chain_en  = (state_q == SHIFT);
        ser_d     = (state_q == SHIFT) && shreg_q[WIDTH-1];
        chain_rst = reset || (state_q == CLR);
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end
endmodule
